// File: rtl/tpu_matmul_sequencer.sv
// Matrix-multiply job sequencer: fetches weights, reloads the systolic array, then streams
// unified-buffer rows and writes the deskewed result rows back after a fixed latency.
module tpu_matmul_sequencer #(
   parameter int ADDRESSSIZE = 10,
   parameter int MATRIX_SIZE = 16,
   parameter int WLOAD_LAT   = 2,
   parameter int RESULT_LAT  = 2*MATRIX_SIZE+1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDRESSSIZE-1:0] base_addr,
   input  logic [ADDRESSSIZE-1:0] num_rows,
   output logic                   busy,
   output logic                   done,
   output logic                   fifo_read_enable,
   output logic                   we_rl,
   output logic [ADDRESSSIZE-1:0] ub_address,
   output logic                   ub_read_valid,
   output logic                   res_write_enable,
   output logic [ADDRESSSIZE-1:0] res_address,
   output logic [2:0]             state
);

   localparam int TW = ADDRESSSIZE + 8;
   localparam logic [TW-1:0] RL      = TW'(RESULT_LAT);
   localparam logic [7:0]    WL_LAST = (WLOAD_LAT > 0) ? 8'(WLOAD_LAT - 1) : 8'd0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_W_FETCH = 3'd1,
      S_W_WAIT  = 3'd2,
      S_W_LOAD  = 3'd3,
      S_RUN     = 3'd4
   } state_t;

   state_t                 r_state;
   logic [TW-1:0]          r_t;
   logic [7:0]             r_wait;
   logic [ADDRESSSIZE-1:0] r_base;
   logic [ADDRESSSIZE-1:0] r_rows;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_fre;
   logic                   r_we_rl;
   logic                   r_ub_valid;
   logic [ADDRESSSIZE-1:0] r_ub_addr;
   logic                   r_res_we;
   logic [ADDRESSSIZE-1:0] r_res_addr;

   // Outputs are registered one cycle ahead, so the run-phase decode looks at the
   // value t will hold in the next cycle (0 when entering RUN from W_LOAD).
   logic [TW-1:0]          w_t_next;
   logic [TW-1:0]          w_rows_ext;
   logic                   w_stream;
   logic                   w_write;
   logic                   w_fin;
   logic [ADDRESSSIZE-1:0] w_ub_addr;
   logic [ADDRESSSIZE-1:0] w_res_addr;

   assign w_t_next   = (r_state == S_RUN) ? r_t + TW'(1) : '0;
   assign w_rows_ext = TW'(r_rows);
   assign w_stream   = (w_t_next < w_rows_ext);
   assign w_write    = (w_t_next >= RL) && (w_t_next < RL + w_rows_ext);
   assign w_fin      = (w_t_next == RL + w_rows_ext);
   assign w_ub_addr  = r_base + w_t_next[ADDRESSSIZE-1:0];
   assign w_res_addr = w_t_next[ADDRESSSIZE-1:0] - RL[ADDRESSSIZE-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_t        <= '0;
         r_wait     <= '0;
         r_base     <= '0;
         r_rows     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fre      <= 1'b0;
         r_we_rl    <= 1'b0;
         r_ub_valid <= 1'b0;
         r_ub_addr  <= '0;
         r_res_we   <= 1'b0;
         r_res_addr <= '0;
      end else begin
         r_fre      <= 1'b0;
         r_we_rl    <= 1'b0;
         r_ub_valid <= 1'b0;
         r_res_we   <= 1'b0;
         r_done     <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && (num_rows != '0) && !abort) begin
                     r_base  <= base_addr;
                     r_rows  <= num_rows;
                     r_state <= S_W_FETCH;
                     r_busy  <= 1'b1;
                     r_fre   <= 1'b1;
                  end
               end
               S_W_FETCH: begin
                  r_wait <= '0;
                  if (WLOAD_LAT == 0) begin
                     r_state <= S_W_LOAD;
                     r_we_rl <= 1'b1;
                  end else begin
                     r_state <= S_W_WAIT;
                  end
               end
               S_W_WAIT: begin
                  if (r_wait == WL_LAST) begin
                     r_state <= S_W_LOAD;
                     r_we_rl <= 1'b1;
                  end else begin
                     r_wait <= r_wait + 8'd1;
                  end
               end
               S_W_LOAD, S_RUN: begin
                  if ((r_state == S_RUN) && r_done) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state    <= S_RUN;
                     r_t        <= w_t_next;
                     r_ub_valid <= w_stream;
                     r_res_we   <= w_write;
                     r_done     <= w_fin;
                     if (w_stream) r_ub_addr  <= w_ub_addr;
                     if (w_write)  r_res_addr <= w_res_addr;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign fifo_read_enable = r_fre;
   assign we_rl            = r_we_rl;
   assign ub_address       = r_ub_addr;
   assign ub_read_valid    = r_ub_valid;
   assign res_write_enable = r_res_we;
   assign res_address      = r_res_addr;
   assign state            = r_state;

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Directed bench for tpu_matmul_sequencer: per-job expected strobe events (cycle, value)
// are queued when a start is driven and popped as the DUT raises each strobe.
module tb_tpu_matmul_sequencer;

   localparam int A  = 10;
   localparam int WL = 2;
   localparam int RL = 33;

   typedef struct packed {
      logic [31:0] cyc;
      logic [15:0] val;
   } ev_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [A-1:0] base_addr = '0;
   logic [A-1:0] num_rows = '0;
   logic         busy, done, fifo_read_enable, we_rl, ub_read_valid, res_write_enable;
   logic [A-1:0] ub_address, res_address;
   logic [2:0]   state;

   int  edge_cnt = 0;
   int  total = 0;
   int  bad = 0;
   int  busy_lo = 1;
   int  busy_hi = 0;
   int  last_s = 0;
   int  mon_c;
   ev_t mon_e;
   ev_t ub_q[$], res_q[$], fre_q[$], we_q[$], done_q[$];

   tpu_matmul_sequencer dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .base_addr(base_addr), .num_rows(num_rows),
      .busy(busy), .done(done), .fifo_read_enable(fifo_read_enable), .we_rl(we_rl),
      .ub_address(ub_address), .ub_read_valid(ub_read_valid),
      .res_write_enable(res_write_enable), .res_address(res_address), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at the drive point of the cycle whose closing edge samples start.
   task automatic push_job(input int base, input int n);
      int s, r0;
      s  = edge_cnt;
      r0 = s + 3 + WL;
      last_s = s;
      fre_q.push_back('{cyc: 32'(s + 1), val: 16'h0});
      we_q.push_back('{cyc: 32'(s + 2 + WL), val: 16'h0});
      for (int i = 0; i < n; i++) begin
         ub_q.push_back('{cyc: 32'(r0 + i), val: 16'((base + i) % (1 << A))});
         res_q.push_back('{cyc: 32'(r0 + RL + i), val: 16'(i)});
      end
      done_q.push_back('{cyc: 32'(r0 + RL + n), val: 16'h0});
      busy_lo = s + 1;
      busy_hi = r0 + RL + n;
   endtask

   task automatic trunc(input int a);
      while (ub_q.size() > 0 && int'(ub_q[$].cyc) > a) void'(ub_q.pop_back());
      while (res_q.size() > 0 && int'(res_q[$].cyc) > a) void'(res_q.pop_back());
      while (fre_q.size() > 0 && int'(fre_q[$].cyc) > a) void'(fre_q.pop_back());
      while (we_q.size() > 0 && int'(we_q[$].cyc) > a) void'(we_q.pop_back());
      while (done_q.size() > 0 && int'(done_q[$].cyc) > a) void'(done_q.pop_back());
      busy_hi = a;
   endtask

   task automatic run_job(input int base, input int n);
      base_addr = A'(base);
      num_rows  = A'(n);
      start     = 1'b1;
      push_job(base, n);
      cyc(1);
      start     = 1'b0;
   endtask

   task automatic drain();
      while (edge_cnt <= busy_hi + 2) cyc(1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fre"}, fifo_read_enable, 0);
      chk({tag, "_we_rl"}, we_rl, 0);
      chk({tag, "_ub_addr"}, ub_address, 0);
      chk({tag, "_ub_valid"}, ub_read_valid, 0);
      chk({tag, "_res_we"}, res_write_enable, 0);
      chk({tag, "_res_addr"}, res_address, 0);
      chk({tag, "_state"}, state, 0);
   endtask

   // Unexpected strobes compare against an all-ones event, which no real cycle matches.
   always @(negedge clk) begin
      if (rstn) begin
         mon_c = edge_cnt;
         chk("busy", busy, (mon_c >= busy_lo && mon_c <= busy_hi));
         if (!(mon_c >= busy_lo && mon_c <= busy_hi)) chk("state_idle", state, 0);
         if (fifo_read_enable) begin
            mon_e = (fre_q.size() > 0) ? fre_q.pop_front() : '1;
            chk("fre", {32'(mon_c), 16'h0}, mon_e);
         end
         if (we_rl) begin
            mon_e = (we_q.size() > 0) ? we_q.pop_front() : '1;
            chk("we_rl", {32'(mon_c), 16'h0}, mon_e);
         end
         if (ub_read_valid) begin
            mon_e = (ub_q.size() > 0) ? ub_q.pop_front() : '1;
            chk("ub", {32'(mon_c), 16'(ub_address)}, mon_e);
         end
         if (res_write_enable) begin
            mon_e = (res_q.size() > 0) ? res_q.pop_front() : '1;
            chk("res", {32'(mon_c), 16'(res_address)}, mon_e);
         end
         if (done) begin
            mon_e = (done_q.size() > 0) ? done_q.pop_front() : '1;
            chk("done", {32'(mon_c), 16'h0}, mon_e);
         end
      end
   end

   initial begin
      int d;
      rstn = 1'b0;
      cyc(3);
      chk_all_zero("reset");
      rstn = 1'b1;
      cyc(2);

      run_job(0, 16);
      drain();
      run_job(1020, 8);
      drain();
      run_job(5, 40);
      drain();

      // start held high through the done cycle: exactly one job
      base_addr = 10'd3;
      num_rows  = 10'd4;
      start     = 1'b1;
      push_job(3, 4);
      d = busy_hi;
      while (edge_cnt <= d) cyc(1);
      start = 1'b0;
      drain();

      // abort in W_WAIT
      run_job(0, 16);
      cyc(1);
      abort = 1'b1;
      trunc(last_s + 2);
      cyc(1);
      abort = 1'b0;
      drain();

      // abort in RUN at t=20
      run_job(0, 40);
      while (edge_cnt < last_s + 3 + WL + 20) cyc(1);
      abort = 1'b1;
      trunc(last_s + 3 + WL + 20);
      cyc(1);
      abort = 1'b0;
      drain();

      // abort with start in IDLE, then abort alone, then a normal job
      base_addr = 10'd0;
      num_rows  = 10'd16;
      start     = 1'b1;
      abort     = 1'b1;
      cyc(1);
      start     = 1'b0;
      cyc(1);
      abort     = 1'b0;
      cyc(4);
      run_job(7, 2);
      drain();

      // zero-row start is ignored
      num_rows = 10'd0;
      start    = 1'b1;
      cyc(1);
      start    = 1'b0;
      cyc(5);

      // reset pulse in RUN at t=10
      run_job(0, 16);
      while (edge_cnt < last_s + 3 + WL + 10) cyc(1);
      rstn = 1'b0;
      #1;
      chk_all_zero("midreset");
      ub_q.delete();
      res_q.delete();
      fre_q.delete();
      we_q.delete();
      done_q.delete();
      busy_lo = 1;
      busy_hi = 0;
      cyc(2);
      rstn = 1'b1;
      cyc(1);
      run_job(0, 16);
      drain();

      chk("ub_q_left", ub_q.size(), 0);
      chk("res_q_left", res_q.size(), 0);
      chk("fre_q_left", fre_q.size(), 0);
      chk("we_q_left", we_q.size(), 0);
      chk("done_q_left", done_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
